// File: rtl/bp_pkg.sv
// Shared types for the bimodal branch predictor: in-flight entry,
// FSM state, counter helpers. Optional gshare via BP_GSHARE_EN.
package bp_pkg;

    localparam int BP_PC_W  = 32;
    localparam int BP_IDX_W = 8;
    localparam int BP_CTR_W = 2;

    typedef logic [BP_CTR_W-1:0] ctr_t;

    // Weakly taken: MSB set, all lower bits clear.
    localparam ctr_t WEAK_TAKEN = ctr_t'(1 << (BP_CTR_W - 1));

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bp_state_e;

    typedef struct packed {
        logic [BP_PC_W-1:0]  pc;
        logic [BP_IDX_W-1:0] index;
        logic                pred;
        logic [BP_PC_W-1:0]  alt_pc;
`ifdef BP_GSHARE_EN
        logic [BP_IDX_W-1:0] ghr;
`endif
    } bp_entry_t;

    function automatic ctr_t ctr_inc(input ctr_t c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    function automatic ctr_t ctr_dec(input ctr_t c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of outstanding predictions: push/pop/flush,
// head entry, full/empty flags and occupancy count.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  bp_entry_t                din_i,
    output bp_entry_t                head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    bp_entry_t      mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW:0]    count_q, count_d;

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/bimodal_branch_predictor.sv
// Bimodal PHT predictor with in-flight queue and commit/rollback pulses.
// Ports: predict side (predict, branch_pc, taken_pc, not_taken_pc ->
// prediction, predicted_pc, stall), resolve side (resolve, resolve_pc,
// resolve_taken -> commit, rollback, rollback_pc, resolve_err), occupancy.
// Macro BP_GSHARE_EN: XOR a global history register into the PHT index.
module bimodal_branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W       = BP_PC_W,
    parameter int INDEX_BITS = BP_IDX_W,
    parameter int CTR_BITS   = BP_CTR_W,
    parameter int DEPTH      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   predict,
    input  logic [PC_W-1:0]        branch_pc,
    input  logic [PC_W-1:0]        taken_pc,
    input  logic [PC_W-1:0]        not_taken_pc,
    output logic                   prediction,
    output logic [PC_W-1:0]        predicted_pc,
    output logic                   stall,
    input  logic                   resolve,
    input  logic [PC_W-1:0]        resolve_pc,
    input  logic                   resolve_taken,
    output logic                   commit,
    output logic                   rollback,
    output logic [PC_W-1:0]        rollback_pc,
    output logic                   resolve_err,
    output logic [$clog2(DEPTH):0] occupancy
);

    bp_state_e             state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [CTR_BITS-1:0]   pht_q [2**INDEX_BITS];

    logic [INDEX_BITS-1:0] lookup_idx;
    logic                  run;
    logic                  accept;
    logic                  res_valid;
    logic                  res_ok;
    logic                  flush;
    logic                  res_err;
    ctr_t                  ctr_upd;

    bp_entry_t             entry_d;
    bp_entry_t             head;
    logic                  full;
    logic                  empty;

    logic                  commit_q;
    logic                  rollback_q;
    logic [PC_W-1:0]       rollback_pc_q;
    logic                  resolve_err_q;

`ifdef BP_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q, ghr_d;
    assign lookup_idx = branch_pc[INDEX_BITS+1:2] ^ ghr_q;
`else
    assign lookup_idx = branch_pc[INDEX_BITS+1:2];
`endif

    assign run          = (state_q == ST_RUN);
    assign prediction   = pht_q[lookup_idx][CTR_BITS-1];
    assign predicted_pc = prediction ? taken_pc : not_taken_pc;
    assign stall        = !run || full;

    // Only the oldest branch may resolve; anything else is an error.
    assign res_valid = run && resolve && !empty && (resolve_pc == head.pc);
    assign res_err   = run && resolve && !res_valid;
    assign res_ok    = res_valid && (resolve_taken == head.pred);
    assign flush     = res_valid && !res_ok;
    assign accept    = run && predict && !full && !flush;

    assign ctr_upd = resolve_taken ? ctr_inc(pht_q[head.index])
                                   : ctr_dec(pht_q[head.index]);

    always_comb begin
        entry_d        = '0;
        entry_d.pc     = branch_pc;
        entry_d.index  = lookup_idx;
        entry_d.pred   = prediction;
        entry_d.alt_pc = prediction ? not_taken_pc : taken_pc;
`ifdef BP_GSHARE_EN
        entry_d.ghr    = ghr_q;
`endif
    end

    bp_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (accept),
        .pop_i   (res_ok),
        .flush_i (flush),
        .din_i   (entry_d),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occupancy)
    );

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == ST_INIT) begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == '1) state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Lookups read the array before this edge's write lands, so a
    // same-cycle lookup of the updated index sees the old counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                pht_q[init_idx_q] <= WEAK_TAKEN;
            end else if (res_valid) begin
                pht_q[head.index] <= ctr_upd;
            end
        end
    end

`ifdef BP_GSHARE_EN
    always_comb begin
        ghr_d = ghr_q;
        if (flush) begin
            ghr_d = {head.ghr[INDEX_BITS-2:0], resolve_taken};
        end else if (accept) begin
            ghr_d = {ghr_q[INDEX_BITS-2:0], prediction};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_q      <= 1'b0;
            rollback_q    <= 1'b0;
            rollback_pc_q <= '0;
            resolve_err_q <= 1'b0;
        end else begin
            commit_q      <= res_ok;
            rollback_q    <= flush;
            rollback_pc_q <= flush ? head.alt_pc : '0;
            resolve_err_q <= res_err;
        end
    end

    assign commit      = commit_q;
    assign rollback    = rollback_q;
    assign rollback_pc = rollback_pc_q;
    assign resolve_err = resolve_err_q;

endmodule

// File: tb/tb_bimodal_branch_predictor.sv
// Directed bench for bimodal_branch_predictor (default build).
// Cycle table plus hand-written init and mid-run reset sequences.
module tb_bimodal_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        predict;
    logic [31:0] branch_pc, taken_pc, not_taken_pc;
    logic        prediction;
    logic [31:0] predicted_pc;
    logic        stall;
    logic        resolve;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic        commit, rollback, resolve_err;
    logic [31:0] rollback_pc;
    logic [2:0]  occupancy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bimodal_branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .predict       (predict),
        .branch_pc     (branch_pc),
        .taken_pc      (taken_pc),
        .not_taken_pc  (not_taken_pc),
        .prediction    (prediction),
        .predicted_pc  (predicted_pc),
        .stall         (stall),
        .resolve       (resolve),
        .resolve_pc    (resolve_pc),
        .resolve_taken (resolve_taken),
        .commit        (commit),
        .rollback      (rollback),
        .rollback_pc   (rollback_pc),
        .resolve_err   (resolve_err),
        .occupancy     (occupancy)
    );

    typedef struct {
        logic        pr;
        logic [31:0] bpc, tpc, npc;
        logic        rs;
        logic [31:0] rpc;
        logic        rt;
        logic        e_pred;
        logic [31:0] e_ppc;
        logic        e_stall, e_com, e_rb;
        logic [31:0] e_rbpc;
        logic        e_err;
        int          e_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic pr, input logic [31:0] bpc, tpc, npc,
        input logic rs, input logic [31:0] rpc, input logic rt,
        input logic e_pred, input logic [31:0] e_ppc,
        input logic e_stall, e_com, e_rb, input logic [31:0] e_rbpc,
        input logic e_err, input int e_occ);
        vec_t v;
        v.pr = pr; v.bpc = bpc; v.tpc = tpc; v.npc = npc;
        v.rs = rs; v.rpc = rpc; v.rt = rt;
        v.e_pred = e_pred; v.e_ppc = e_ppc; v.e_stall = e_stall;
        v.e_com = e_com; v.e_rb = e_rb; v.e_rbpc = e_rbpc;
        v.e_err = e_err; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        predict = 1'b0; branch_pc = '0; taken_pc = '0; not_taken_pc = '0;
        resolve = 1'b0; resolve_pc = '0; resolve_taken = 1'b0;
    endtask

    // Release reset and count INIT cycles; resolve is held high to
    // confirm it is ignored while the table initialises.
    task automatic run_init(input string tag);
        int cnt = 0;
        int errs = 0;
        rst = 1'b0;
        resolve = 1'b1; resolve_pc = 32'h100; resolve_taken = 1'b1;
        while (stall === 1'b1 && cnt < 400) begin
            cnt++;
            if (resolve_err !== 1'b0 || commit !== 1'b0) errs++;
            step();
        end
        idle_inputs();
        chk({tag, ".init_cycles"}, 32'(cnt), 32'd256);
        chk({tag, ".init_resolve_ignored"}, 32'(errs), 32'd0);
        chk({tag, ".run_err"}, {31'b0, resolve_err}, 32'd0);
        chk({tag, ".run_occ"}, 32'(occupancy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // pr bpc tpc npc | rs rpc rt | pred ppc stall | com rb rbpc err occ
        vecs.push_back(mk(1,'h100,'h200,'h108, 0,0,0,     1,'h200,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h100,1, 0,0,0,     1,0,0,0,0));
        vecs.push_back(mk(1,'h100,'h200,'h108, 0,0,0,     1,'h200,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h100,0, 0,0,0,     0,1,'h108,0,0));
        vecs.push_back(mk(1,'h100,'h200,'h108, 0,0,0,     1,'h200,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h100,0, 0,0,0,     0,1,'h108,0,0));
        vecs.push_back(mk(1,'h100,'h200,'h108, 0,0,0,     0,'h108,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h100,0, 0,0,0,     1,0,0,0,0));
        vecs.push_back(mk(1,'h100,'h200,'h108, 0,0,0,     0,'h108,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h100,1, 0,0,0,     0,1,'h200,0,0));
        vecs.push_back(mk(0,0,0,0,             1,'h100,1, 0,0,0,     0,0,0,1,0));
        vecs.push_back(mk(1,'h100,'h200,'h108, 0,0,0,     0,'h108,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h300,1, 0,0,0,     0,0,0,1,1));
        vecs.push_back(mk(1,'h100,'h200,'h108, 0,0,0,     0,'h108,0, 0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,             1,'h100,0, 0,0,0,     1,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h100,0, 0,0,0,     1,0,0,0,0));
        vecs.push_back(mk(1,'h100,'h200,'h108, 0,0,0,     0,'h108,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h100,0, 0,0,0,     1,0,0,0,0));
        vecs.push_back(mk(1,'h104,'h204,'h10c, 0,0,0,     1,'h204,0, 0,0,0,0,1));
        vecs.push_back(mk(1,'h108,'h208,'h110, 0,0,0,     1,'h208,0, 0,0,0,0,2));
        vecs.push_back(mk(1,'h10c,'h20c,'h114, 0,0,0,     1,'h20c,0, 0,0,0,0,3));
        vecs.push_back(mk(1,'h110,'h210,'h118, 0,0,0,     1,'h210,0, 0,0,0,0,4));
        vecs.push_back(mk(1,'h114,'h214,'h11c, 0,0,0,     1,'h214,1, 0,0,0,0,4));
        vecs.push_back(mk(1,'h114,'h214,'h11c, 1,'h104,1, 1,'h214,1, 1,0,0,0,3));
        vecs.push_back(mk(1,'h114,'h214,'h11c, 1,'h108,1, 1,'h214,0, 1,0,0,0,3));
        vecs.push_back(mk(1,'h118,'h218,'h120, 1,'h10c,0, 1,'h218,0, 0,1,'h114,0,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,     0,0,0,     0,0,0,0,0));
        vecs.push_back(mk(1,'h10c,'h20c,'h114, 0,0,0,     0,'h114,0, 0,0,0,0,1));
        vecs.push_back(mk(1,'h10c,'h20c,'h114, 1,'h10c,1, 0,'h114,0, 0,1,'h20c,0,0));
        vecs.push_back(mk(1,'h10c,'h20c,'h114, 0,0,0,     1,'h20c,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h10c,1, 0,0,0,     1,0,0,0,0));
        vecs.push_back(mk(1,'h108,'h208,'h110, 0,0,0,     1,'h208,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h108,1, 0,0,0,     1,0,0,0,0));
        vecs.push_back(mk(1,'h108,'h208,'h110, 0,0,0,     1,'h208,0, 0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,             1,'h108,0, 0,0,0,     0,1,'h110,0,0));

        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        chk("rst.occ", 32'(occupancy), 32'd0);
        chk("rst.stall", {31'b0, stall}, 32'd1);
        chk("rst.commit", {31'b0, commit}, 32'd0);
        chk("rst.rollback", {31'b0, rollback}, 32'd0);
        chk("rst.rollback_pc", rollback_pc, 32'd0);
        chk("rst.err", {31'b0, resolve_err}, 32'd0);
        run_init("boot");

        foreach (vecs[i]) begin
            predict = vecs[i].pr; branch_pc = vecs[i].bpc;
            taken_pc = vecs[i].tpc; not_taken_pc = vecs[i].npc;
            resolve = vecs[i].rs; resolve_pc = vecs[i].rpc;
            resolve_taken = vecs[i].rt;
            #1;
            chk($sformatf("v%0d.stall", i), {31'b0, stall},
                {31'b0, vecs[i].e_stall});
            if (vecs[i].pr) begin
                chk($sformatf("v%0d.prediction", i), {31'b0, prediction},
                    {31'b0, vecs[i].e_pred});
                chk($sformatf("v%0d.predicted_pc", i), predicted_pc,
                    vecs[i].e_ppc);
            end
            step();
            chk($sformatf("v%0d.commit", i), {31'b0, commit},
                {31'b0, vecs[i].e_com});
            chk($sformatf("v%0d.rollback", i), {31'b0, rollback},
                {31'b0, vecs[i].e_rb});
            chk($sformatf("v%0d.rollback_pc", i), rollback_pc,
                vecs[i].e_rbpc);
            chk($sformatf("v%0d.resolve_err", i), {31'b0, resolve_err},
                {31'b0, vecs[i].e_err});
            chk($sformatf("v%0d.occupancy", i), 32'(occupancy),
                32'(vecs[i].e_occ));
        end
        idle_inputs();

        // Mid-run reset: outstanding entry dropped, table re-initialised.
        predict = 1'b1; branch_pc = 32'h100;
        taken_pc = 32'h200; not_taken_pc = 32'h108;
        #1;
        chk("mid.pre_pred", {31'b0, prediction}, 32'd0);
        step();
        chk("mid.pre_occ", 32'(occupancy), 32'd1);
        rst = 1'b1;
        step();
        predict = 1'b0;
        chk("mid.rst_occ", 32'(occupancy), 32'd0);
        chk("mid.rst_stall", {31'b0, stall}, 32'd1);
        chk("mid.rst_commit", {31'b0, commit}, 32'd0);
        run_init("mid");

        predict = 1'b1; branch_pc = 32'h100;
        taken_pc = 32'h200; not_taken_pc = 32'h108;
        #1;
        chk("mid.reinit_pred", {31'b0, prediction}, 32'd1);
        chk("mid.reinit_ppc", predicted_pc, 32'h200);
        step();
        idle_inputs();
        chk("mid.post_occ", 32'(occupancy), 32'd1);
        resolve = 1'b1; resolve_pc = 32'h100; resolve_taken = 1'b1;
        step();
        idle_inputs();
        chk("mid.post_commit", {31'b0, commit}, 32'd1);
        chk("mid.post_occ0", 32'(occupancy), 32'd0);
        step();
        chk("mid.commit_pulse", {31'b0, commit}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
